// File: rtl/foc_pkg.sv
// Shared field-oriented-control definitions: default word format, the
// 1/sqrt(3) Clarke constant and the transform sequencer states.
package foc_pkg;

    localparam int FOC_N = 10;
    localparam int FOC_F = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BETA,
        ST_M_AC,
        ST_M_BS,
        ST_M_AS,
        ST_M_BC,
        ST_DONE
    } foc_state_e;

    // round(2^f / sqrt(3)): smallest k with 3*(2k+1)^2 > 4^(f+1)
    function automatic int foc_k(input int f);
        longint lim;
        int     k;
        lim = longint'(1) << (2 * f + 2);
        k   = 0;
        while (longint'(3) * (2 * longint'(k) + 1) * (2 * longint'(k) + 1) <= lim)
            k++;
        return k;
    endfunction

    localparam int FOC_K = foc_k(FOC_F);

endpackage

// File: rtl/clarke_park_if.sv
// Request/result bundle between a current-loop master and the
// Clarke/Park transform.
interface clarke_park_if
    import foc_pkg::*;
#(
    parameter int N = FOC_N
);
    logic                en;
    logic                start;
    logic signed [N-1:0] i_a;
    logic signed [N-1:0] i_b;
    logic signed [N-1:0] sin_theta;
    logic signed [N-1:0] cos_theta;
    logic signed [N-1:0] i_d;
    logic signed [N-1:0] i_q;
    logic                valid;
    logic                busy;

    modport master (
        output en, start, i_a, i_b, sin_theta, cos_theta,
        input  i_d, i_q, valid, busy
    );

    modport slave (
        input  en, start, i_a, i_b, sin_theta, cos_theta,
        output i_d, i_q, valid, busy
    );
endinterface

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full product, round half up at bit F,
// arithmetic shift right by F, saturate to OW bits.
module fxp_mul_sat #(
    parameter int AW = 12,
    parameter int BW = 10,
    parameter int OW = 10,
    parameter int F  = 9
) (
    input  logic signed [AW-1:0] i_a,
    input  logic signed [BW-1:0] i_b,
    output logic signed [OW-1:0] o_p
);
    localparam int PW = AW + BW;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (F - 1);
    localparam logic signed [PW-1:0] PMAX = PW'((2 ** (OW - 1)) - 1);
    localparam logic signed [PW-1:0] PMIN = ~PMAX;

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_rnd;
    logic signed [PW-1:0] w_shift;

    always_comb begin
        w_prod  = PW'(i_a) * PW'(i_b);
        w_rnd   = w_prod + HALF;
        w_shift = w_rnd >>> F;
        if (w_shift > PMAX)
            o_p = OW'(PMAX);
        else if (w_shift < PMIN)
            o_p = OW'(PMIN);
        else
            o_p = w_shift[OW-1:0];
    end
endmodule

// File: rtl/clarke_park.sv
// Clarke then Park transform of two phase currents into d/q, one product
// per enabled cycle through a single shared multiplier.
module clarke_park
    import foc_pkg::*;
#(
    parameter int N = FOC_N,
    parameter int F = FOC_F
) (
    input  logic         clk,
    input  logic         nrst,
    clarke_park_if.slave bus
);
    localparam logic signed [N-1:0] K = N'(foc_k(F));

    foc_state_e          r_state;
    foc_state_e          w_next;
    logic signed [N-1:0] r_a, r_b, r_sin, r_cos;
    logic signed [N-1:0] r_beta, r_pac, r_pd, r_pas;
    logic signed [N-1:0] r_id, r_iq;
    logic signed [N+1:0] w_ma;
    logic signed [N-1:0] w_mb;
    logic signed [N-1:0] w_prod;
    logic signed [N:0]   w_sum_d;
    logic signed [N:0]   w_diff_q;

    function automatic logic signed [N-1:0] sat_n(input logic signed [N:0] v);
        if (v[N] != v[N-1])
            return v[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        return v[N-1:0];
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_BETA;
            ST_BETA: w_next = ST_M_AC;
            ST_M_AC: w_next = ST_M_BS;
            ST_M_BS: w_next = ST_M_AS;
            ST_M_AS: w_next = ST_M_BC;
            ST_M_BC: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand select: i_beta = (i_a + 2*i_b) * K first, then the four Park products
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
            ST_BETA: begin
                w_ma = {{2{r_a[N-1]}}, r_a} + {r_b[N-1], r_b, 1'b0};
                w_mb = K;
            end
            ST_M_AC: begin w_ma = {{2{r_a[N-1]}}, r_a};       w_mb = r_cos; end
            ST_M_BS: begin w_ma = {{2{r_beta[N-1]}}, r_beta}; w_mb = r_sin; end
            ST_M_AS: begin w_ma = {{2{r_a[N-1]}}, r_a};       w_mb = r_sin; end
            ST_M_BC: begin w_ma = {{2{r_beta[N-1]}}, r_beta}; w_mb = r_cos; end
            default: ;
        endcase
    end

    fxp_mul_sat #(.AW(N + 2), .BW(N), .OW(N), .F(F)) u_mul (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_prod)
    );

    assign w_sum_d  = {r_pac[N-1], r_pac} + {w_prod[N-1], w_prod};
    assign w_diff_q = {w_prod[N-1], w_prod} - {r_pas[N-1], r_pas};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_beta  <= '0;
            r_pac   <= '0;
            r_pd    <= '0;
            r_pas   <= '0;
            r_id    <= '0;
            r_iq    <= '0;
        end else if (bus.en) begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_a   <= bus.i_a;
                    r_b   <= bus.i_b;
                    r_sin <= bus.sin_theta;
                    r_cos <= bus.cos_theta;
                end
                ST_BETA: r_beta <= w_prod;
                ST_M_AC: r_pac  <= w_prod;
                ST_M_BS: r_pd   <= sat_n(w_sum_d);
                ST_M_AS: r_pas  <= w_prod;
                ST_M_BC: begin
                    r_id <= r_pd;
                    r_iq <= sat_n(w_diff_q);
                end
                default: ;
            endcase
        end
    end

    // Gating with en keeps a stalled DONE from showing a pulse twice
    assign bus.valid = (r_state == ST_DONE) && bus.en;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.i_d   = r_id;
    assign bus.i_q   = r_iq;
endmodule

// File: doc/clarke_park.md
CLARKE_PARK -- requirements
Module: clarke_park

Interface
REQ-001 SHALL have parameter N, default 10, meaning signed word width of all current and trig ports.
REQ-002 SHALL have parameter F, default 9, meaning number of fractional bits (Q format, full scale ±1.0).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  clock enable; low freezes all state and outputs.
REQ-006 SHALL have port start  input  1  request one transform; sampled only in IDLE with en high.
REQ-007 SHALL have ports i_a, i_b  input  N  signed measured phase currents (i_c implied = -i_a-i_b).
REQ-008 SHALL have ports sin_theta, cos_theta  input  N  signed rotor-angle trig values, Q(F).
REQ-009 SHALL have ports i_d, i_q  output  N  signed rotor-frame currents feeding the current controller.
REQ-010 SHALL have port valid  output  1  one-cycle pulse, i_d/i_q updated this cycle.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL compute i_alpha = i_a; i_beta = (i_a + 2*i_b) * K, K = round(2^F/sqrt3) (296 for F=9), sum formed in N+2 bits.
REQ-013 SHALL compute i_d = i_alpha*cos + i_beta*sin; i_q = i_beta*cos - i_alpha*sin.
REQ-014 SHALL use exactly one time-shared signed multiplier (one product per enabled cycle).
REQ-015 SHALL form each product at 2N+2 bits, add 2^(F-1), arithmetic-shift right F (round half up), saturate to N bits.
REQ-016 SHALL form each sum/difference of two rounded products in N+1 bits then saturate to [-2^(N-1), 2^(N-1)-1].
REQ-017 SHALL latch i_a, i_b, sin_theta, cos_theta on the start-accept edge; later input changes SHALL not affect the result.
REQ-018 SHALL sequence FSM IDLE -> BETA -> M_AC -> M_BS -> M_AS -> M_BC -> DONE -> IDLE, one state per enabled cycle.
REQ-019 SHALL in DONE register i_d, i_q and assert valid for exactly one cycle; latency start-accept edge to valid = 6 enabled cycles.
REQ-020 SHALL hold i_d, i_q unchanged between valid pulses.
REQ-021 SHALL ignore start while busy (no queueing); start high in DONE's following IDLE cycle SHALL be accepted (back-to-back every 7 cycles).
REQ-022 SHALL with en low hold state, intermediates, outputs; a valid pulse SHALL not be stretched or repeated across an en-low stall (valid low while en low).

Reset
REQ-023 SHALL on nrst low immediately force state IDLE, i_d = 0, i_q = 0, valid = 0, busy = 0, intermediates = 0.
REQ-024 SHALL on reset mid-operation discard the in-flight transform; no valid SHALL follow release until a new start.

Structure
REQ-025 SHALL take N, F defaults, K constant and state enum from shared package foc_pkg.
REQ-026 SHALL instantiate one sub-module fxp_mul_sat (signed multiply, round, saturate), reusable by pi_controller.
REQ-027 SHALL be 120-400 lines RTL, no vendor primitives.

Verification (N=10, F=9)
REQ-028 i_a=256, i_b=-128, cos=511, sin=0, start -> valid after 6 cycles, i_d=256, i_q=0.
REQ-029 i_a=256, i_b=-128, cos=0, sin=511 -> i_d=0, i_q=-256.
REQ-030 i_a=511, i_b=511, cos=sin=362 -> i_beta saturates 511, i_d=511 (saturated), i_q=0.
REQ-031 start pulses at cycles 0 and 3 -> exactly one valid, at cycle 6; inputs changed at cycle 1 do not alter result.
REQ-032 en low 3 cycles during M_BS -> valid delayed exactly 3 cycles, same values as REQ-028.
REQ-033 nrst low during M_AS -> outputs 0, busy 0 immediately; no valid after release without new start.
